// File: rtl/vec_mem_pkg.sv
// rtl/vec_mem_pkg.sv - shared types, constants and helpers for the vector memory unit
// Contents: state_t (IDLE/SEQ), lane_t (one lane word), WORD_SHIFT (byte->word),
//           lane_in_range(base, stride, k, depth) range check for lane k.
package vec_mem_pkg;

  localparam int LANE_W     = 32;
  localparam int WORD_SHIFT = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_t;

  typedef logic [LANE_W-1:0] lane_t;

  // Word index of lane k is base + k*stride; 64-bit math keeps it wrap-free
  // for any realistic ADDR_W + STRIDE_W + LANES.
  function automatic logic lane_in_range(input logic [63:0] base,
                                         input logic [63:0] stride,
                                         input int          k,
                                         input int          depth);
    logic [63:0] w;
    w = base + 64'(k) * stride;
    return w < 64'(depth);
  endfunction

endpackage

// File: rtl/vec_mem_unit_if.sv
// rtl/vec_mem_unit_if.sv - request/response bundle of the vector memory unit
// Request : req_valid, req_ready, req_we, req_addr, req_stride, req_mask, req_wdata
// Response: rsp_valid, rsp_rdata, rsp_err
// master = requester (datapath / bench), slave = vec_mem_unit.
interface vec_mem_unit_if #(
  parameter int DATA_W   = 32,
  parameter int LANES    = 8,
  parameter int ADDR_W   = 32,
  parameter int STRIDE_W = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_W-1:0]       req_addr;
  logic [STRIDE_W-1:0]     req_stride;
  logic [LANES-1:0]        req_mask;
  logic [LANES*DATA_W-1:0] req_wdata;
  logic                    rsp_valid;
  logic [LANES*DATA_W-1:0] rsp_rdata;
  logic                    rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_stride, req_mask, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_stride, req_mask, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/vec_mem_lane_gen.sv
// rtl/vec_mem_lane_gen.sv - lane counter and running word address for strided access
// Ports: clk, rst (sync, active high), start (load base, lane 0), step (advance one lane),
//        base_word, stride in; lane_idx, word_addr, in_range, last out.
module vec_mem_lane_gen #(
  parameter int LANES    = 8,
  parameter int WA_W     = 48,
  parameter int STRIDE_W = 8,
  parameter int DEPTH    = 256,
  parameter int LIDX_W   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                step,
  input  logic [WA_W-1:0]     base_word,
  input  logic [STRIDE_W-1:0] stride,
  output logic [LIDX_W-1:0]   lane_idx,
  output logic [WA_W-1:0]     word_addr,
  output logic                in_range,
  output logic                last
);

  logic [STRIDE_W-1:0] stride_q;

  // Accumulating the address avoids a per-lane multiplier; WA_W is wide
  // enough that base + (LANES-1)*stride never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_idx  <= '0;
      word_addr <= '0;
      stride_q  <= '0;
    end else if (start) begin
      lane_idx  <= '0;
      word_addr <= base_word;
      stride_q  <= stride;
    end else if (step) begin
      lane_idx  <= lane_idx + LIDX_W'(1);
      word_addr <= word_addr + WA_W'(stride_q);
    end
  end

  assign in_range = word_addr < WA_W'(DEPTH);
  assign last     = lane_idx == LIDX_W'(LANES - 1);

endmodule

// File: rtl/vec_mem_unit.sv
// rtl/vec_mem_unit.sv - vector data memory with masked, strided lane access
// Ports: clk, rst (sync, active high), bus (vec_mem_unit_if.slave):
//   request  req_valid/req_ready/req_we/req_addr/req_stride/req_mask/req_wdata
//   response rsp_valid (1-cycle pulse), rsp_rdata, rsp_err (held until next response)
// Stride 1 completes all lanes on the accept edge; other strides walk lanes one per cycle.
module vec_mem_unit
  import vec_mem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int LANES    = 8,
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 32,
  parameter int STRIDE_W = 8
) (
  input logic           clk,
  input logic           rst,
  vec_mem_unit_if.slave bus
);

  localparam int WA_W   = ADDR_W + STRIDE_W + LANES;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int VW     = LANES * DATA_W;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t state_q, state_d;

  logic            accept, misalign, unit;
  logic [WA_W-1:0] base_word;
  logic            unit_fire, seq_start, seq_step;

  // unit-stride path
  logic [WA_W-1:0]  u_w   [LANES];
  logic [IDX_W-1:0] u_idx [LANES];
  logic [LANES-1:0] u_inr, u_hit;
  logic             unit_err;
  logic [VW-1:0]    unit_rdata;

  // strided path
  logic [LIDX_W-1:0] lane_idx;
  logic [WA_W-1:0]   word_addr;
  logic              lane_inr, lane_last;
  logic              s_en, s_hit, s_oor;
  logic [IDX_W-1:0]  s_idx;
  logic [VW-1:0]     acc_next;

  // captured request and running result
  logic             we_q, misalign_q, err_q;
  logic [LANES-1:0] mask_q;
  logic [VW-1:0]    wdata_q, acc_q;

  logic             rsp_valid_q, rsp_err_q;
  logic [VW-1:0]    rsp_rdata_q;

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign accept    = bus.req_valid && bus.req_ready;
  assign misalign  = |bus.req_addr[WORD_SHIFT-1:0];
  assign unit      = bus.req_stride == STRIDE_W'(1);
  assign base_word = WA_W'(bus.req_addr >> WORD_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    unit_fire = 1'b0;
    seq_start = 1'b0;
    seq_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && unit) begin
          unit_fire = 1'b1;
        end else if (accept) begin
          seq_start = 1'b1;
          state_d   = SEQ;
        end
      end
      SEQ: begin
        seq_step = 1'b1;
        if (lane_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    unit_err   = misalign;
    unit_rdata = '0;
    u_hit      = '0;
    u_inr      = '0;
    for (int k = 0; k < LANES; k++) begin
      u_w[k]   = base_word + WA_W'(k);
      u_idx[k] = u_w[k][IDX_W-1:0];
      u_inr[k] = lane_in_range(64'(base_word), 64'd1, k, DEPTH);
      u_hit[k] = bus.req_mask[k] && !misalign && u_inr[k];
      if (bus.req_mask[k] && !misalign && !u_inr[k]) unit_err = 1'b1;
      if (u_hit[k] && !bus.req_we) unit_rdata[k*DATA_W +: DATA_W] = mem[u_idx[k]];
    end
  end

  vec_mem_lane_gen #(
    .LANES    (LANES),
    .WA_W     (WA_W),
    .STRIDE_W (STRIDE_W),
    .DEPTH    (DEPTH),
    .LIDX_W   (LIDX_W)
  ) u_lane_gen (
    .clk       (clk),
    .rst       (rst),
    .start     (seq_start),
    .step      (seq_step),
    .base_word (base_word),
    .stride    (bus.req_stride),
    .lane_idx  (lane_idx),
    .word_addr (word_addr),
    .in_range  (lane_inr),
    .last      (lane_last)
  );

  // Loads merge the current lane into the accumulator so the final lane can
  // be returned on the same edge that leaves SEQ; stores leave it at zero.
  always_comb begin
    s_en     = mask_q[lane_idx] && !misalign_q;
    s_hit    = s_en && lane_inr;
    s_oor    = s_en && !lane_inr;
    s_idx    = word_addr[IDX_W-1:0];
    acc_next = acc_q;
    if (s_hit && !we_q) acc_next[int'(lane_idx)*DATA_W +: DATA_W] = mem[s_idx];
  end

  // Array is not reset, but reset blocks writes so an aborted request
  // stops at the lane before the reset edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (unit_fire && bus.req_we) begin
        for (int k = 0; k < LANES; k++) begin
          if (u_hit[k]) mem[u_idx[k]] <= bus.req_wdata[k*DATA_W +: DATA_W];
        end
      end
      if (seq_step && we_q && s_hit) begin
        mem[s_idx] <= wdata_q[int'(lane_idx)*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      we_q        <= 1'b0;
      misalign_q  <= 1'b0;
      mask_q      <= '0;
      wdata_q     <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (unit_fire) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= unit_rdata;
        rsp_err_q   <= unit_err;
      end
      if (seq_start) begin
        we_q       <= bus.req_we;
        misalign_q <= misalign;
        mask_q     <= bus.req_mask;
        wdata_q    <= bus.req_wdata;
        acc_q      <= '0;
        err_q      <= misalign;
      end
      if (seq_step) begin
        acc_q <= acc_next;
        err_q <= err_q | s_oor;
        if (lane_last) begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= acc_next;
          rsp_err_q   <= err_q | s_oor;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_mem_unit.sv
// tb/tb_vec_mem_unit.sv - self-checking bench for vec_mem_unit against an array model
module tb_vec_mem_unit;
  import vec_mem_pkg::*;

  localparam int DATA_W   = 32;
  localparam int LANES    = 8;
  localparam int DEPTH    = 256;
  localparam int ADDR_W   = 32;
  localparam int STRIDE_W = 8;
  localparam int VW       = LANES * DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vec_mem_unit_if #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W)) bus ();

  vec_mem_unit #(
    .DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  lane_t mm [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural reference: lanes visited in ascending order on a plain array.
  task automatic model_access(input bit we, input logic [31:0] addr, input int stride,
                              input logic [LANES-1:0] mask, input logic [VW-1:0] wdata,
                              output logic [VW-1:0] rd, output logic err);
    longint w;
    rd  = '0;
    err = 1'b0;
    if (addr[1:0] != 2'b00) begin
      err = 1'b1;
      return;
    end
    for (int k = 0; k < LANES; k++) begin
      w = longint'(addr >> 2) + longint'(k) * stride;
      if (mask[k]) begin
        if (w >= DEPTH) err = 1'b1;
        else if (we) mm[int'(w)] = wdata[k*DATA_W +: DATA_W];
        else rd[k*DATA_W +: DATA_W] = mm[int'(w)];
      end
    end
  endtask

  task automatic do_req(input string tag, input bit we, input logic [31:0] addr,
                        input logic [7:0] stride, input logic [LANES-1:0] mask,
                        input logic [VW-1:0] wdata);
    logic [VW-1:0] exp_rd, held;
    logic exp_err;
    int lat, low;
    bit got;
    model_access(we, addr, int'(stride), mask, wdata, exp_rd, exp_err);
    for (int i = 0; i < 30 && !bus.req_ready; i++) @(negedge clk);
    chk({tag, "_ready"}, VW'(bus.req_ready), VW'(1));
    bus.req_we = we; bus.req_addr = addr; bus.req_stride = stride;
    bus.req_mask = mask; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    got = 0; lat = 0; low = 0;
    for (int i = 1; i <= LANES + 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin got = 1; lat = i; break; end
      if (!bus.req_ready) low++;
    end
    chk({tag, "_rsp_seen"}, VW'(got), VW'(1));
    chk({tag, "_latency"}, VW'(lat), VW'((stride == 8'd1) ? 1 : LANES + 1));
    chk({tag, "_ready_low"}, VW'(low), VW'((stride == 8'd1) ? 0 : LANES));
    chk({tag, "_rdata"}, bus.rsp_rdata, exp_rd);
    chk({tag, "_err"}, VW'(bus.rsp_err), VW'(exp_err));
    held = bus.rsp_rdata;
    @(negedge clk);
    chk({tag, "_pulse"}, VW'(bus.rsp_valid), VW'(0));
    chk({tag, "_hold"}, bus.rsp_rdata, held);
  endtask

  initial begin : main
    logic [VW-1:0] wd, exp, rd_d;
    logic err_d;
    logic [31:0] addr;
    logic [7:0] stride;
    int p1 [LANES] = '{50, 100, 11, 23, 1, 2, 3, 4};
    int hits;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_stride = '0; bus.req_mask = '0; bus.req_wdata = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", VW'(bus.rsp_valid), VW'(0));
    chk("rst_rsp_rdata", bus.rsp_rdata, VW'(0));
    chk("rst_rsp_err", VW'(bus.rsp_err), VW'(0));
    chk("rst_req_ready", VW'(bus.req_ready), VW'(1));
    rst = 1'b0;
    @(negedge clk);

    // fill the whole array with random words so every later load is defined
    for (int b = 0; b < DEPTH / LANES; b++) begin
      for (int k = 0; k < LANES; k++) wd[k*DATA_W +: DATA_W] = $urandom;
      do_req("fill", 1'b1, 32'(b * LANES * 4), 8'd1, '1, wd);
    end

    // unit-stride store/load round trip
    for (int k = 0; k < LANES; k++) wd[k*DATA_W +: DATA_W] = 32'(p1[k]);
    do_req("u_st", 1'b1, 32'h0, 8'd1, 8'hFF, wd);
    do_req("u_ld", 1'b0, 32'h0, 8'd1, 8'hFF, '0);
    chk("u_ld_const", bus.rsp_rdata, wd);

    // word i holds i, then stride-2 load
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < LANES; k++) wd[k*DATA_W +: DATA_W] = 32'(b * LANES + k);
      do_req("idx_st", 1'b1, 32'(b * LANES * 4), 8'd1, 8'hFF, wd);
    end
    do_req("s2_ld", 1'b0, 32'h0, 8'd2, 8'hFF, '0);
    for (int k = 0; k < LANES; k++) exp[k*DATA_W +: DATA_W] = 32'(2 * k);
    chk("s2_const", bus.rsp_rdata, exp);

    // stride-0 store: highest enabled lane wins; stride-0 load broadcasts
    for (int k = 0; k < LANES; k++) wd[k*DATA_W +: DATA_W] = 32'(k * 10);
    do_req("s0_st", 1'b1, 32'h40, 8'd0, 8'b1000_0110, wd);
    do_req("s0_ld", 1'b0, 32'h40, 8'd0, 8'b1000_0110, '0);
    exp = '0;
    exp[1*DATA_W +: DATA_W] = 32'd70;
    exp[2*DATA_W +: DATA_W] = 32'd70;
    exp[7*DATA_W +: DATA_W] = 32'd70;
    chk("s0_const", bus.rsp_rdata, exp);

    // unit-stride load straddling the top of the array
    do_req("top_ld", 1'b0, 32'(4 * (DEPTH - 4)), 8'd1, 8'hFF, '0);
    chk("top_err_const", VW'(bus.rsp_err), VW'(1));
    chk("top_hi_zero", VW'(bus.rsp_rdata[VW-1:4*DATA_W]), VW'(0));

    // misaligned store must not touch the array
    for (int k = 0; k < LANES; k++) wd[k*DATA_W +: DATA_W] = $urandom;
    do_req("mis_st", 1'b1, 32'h2, 8'd1, 8'hFF, wd);
    chk("mis_err_const", VW'(bus.rsp_err), VW'(1));
    do_req("mis_ld", 1'b0, 32'h2, 8'd3, 8'hFF, '0);
    chk("mis_rdata_const", bus.rsp_rdata, VW'(0));
    do_req("mis_after", 1'b0, 32'h0, 8'd1, 8'hFF, '0);

    // back-to-back unit store then load sees the new data
    for (int k = 0; k < LANES; k++) wd[k*DATA_W +: DATA_W] = $urandom;
    model_access(1'b1, 32'h80, 1, 8'hFF, wd, rd_d, err_d);
    bus.req_we = 1'b1; bus.req_addr = 32'h80; bus.req_stride = 8'd1;
    bus.req_mask = 8'hFF; bus.req_wdata = wd; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_we = 1'b0;
    @(negedge clk);
    chk("b2b_st_valid", VW'(bus.rsp_valid), VW'(1));
    chk("b2b_st_ready", VW'(bus.req_ready), VW'(1));
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_ld_valid", VW'(bus.rsp_valid), VW'(1));
    chk("b2b_ld_rdata", bus.rsp_rdata, wd);
    @(negedge clk);

    // randomized mix against the model
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 4))
        0: stride = 8'd0;
        1: stride = 8'd1;
        2: stride = 8'd2;
        3: stride = 8'd3;
        default: stride = 8'($urandom_range(4, 255));
      endcase
      addr = 32'($urandom_range(0, DEPTH + 8)) << 2;
      if ($urandom_range(0, 9) == 0) addr = addr | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 19) == 0) addr = 32'hFFFF_FFFC;
      for (int k = 0; k < LANES; k++) wd[k*DATA_W +: DATA_W] = $urandom;
      do_req("rnd", 1'($urandom_range(0, 1)), addr, stride, 8'($urandom), wd);
    end

    // reset during the 4th SEQ cycle of a stride-3 store: only lanes 0-2 land
    for (int k = 0; k < LANES; k++) wd[k*DATA_W +: DATA_W] = $urandom;
    model_access(1'b1, 32'd400, 3, 8'h07, wd, rd_d, err_d);
    bus.req_we = 1'b1; bus.req_addr = 32'd400; bus.req_stride = 8'd3;
    bus.req_mask = 8'hFF; bus.req_wdata = wd; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    hits = 0;
    for (int i = 0; i < LANES + 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) hits++;
    end
    chk("abort_no_rsp", VW'(hits), VW'(0));
    chk("abort_ready", VW'(bus.req_ready), VW'(1));
    do_req("abort_ld", 1'b0, 32'd400, 8'd3, 8'hFF, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_mem_unit.md
Name: vec_mem_unit

Overview:
- Parametrised vector data memory for the ASIP vector datapath.
- Each request moves one vector of LANES words to or from a word-addressed array, with a per-lane mask and a word stride.
- Unit-stride accesses complete in one cycle, with all lanes in parallel.
- Any other stride runs as a sequential per-lane access, one lane per cycle, with a valid/ready request handshake and a one-cycle response pulse.

Parameters:
- DATA_W, 32, lane word width in bits.
- LANES, 8, elements per vector.
- DEPTH, 256, words in the array.
- ADDR_W, 32, byte-address width.
- STRIDE_W, 8, unsigned word-stride width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte base address; bits [1:0] must be 0
- req_stride  in  STRIDE_W  word stride between lanes (0 = broadcast)
- req_mask  in  LANES  lane enables
- req_wdata  in  LANES*DATA_W  store data, lane k at bits [k*DATA_W +: DATA_W]
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  LANES*DATA_W  load data, same lane packing as req_wdata
- rsp_err  out  1  misaligned or out-of-range access; valid only with rsp_valid

Behaviour:
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1, state IDLE.
  - Array contents are not reset.
  - A reset mid-operation aborts the request with no response; lanes already written stay written.
- Accept: a request is accepted on an edge where req_valid && req_ready. The unit captures all request fields.
- Lane address: lane word index w_k = (req_addr>>2) + k*req_stride.
  - Computed in ADDR_W+STRIDE_W+LANES bits, so there is no wrap.
  - A lane is in range iff w_k < DEPTH.
- Misalignment: req_addr[1:0] != 0 gives no array access, rsp_err=1, rsp_rdata=0.
  - Response latency is the same as a normal request of that stride.
- Masked-off lanes: never written; their rsp_rdata is 0.
- Out-of-range enabled lanes: not accessed, rsp_rdata lane is 0, rsp_err=1. Other lanes complete normally.
- Unit stride (req_stride==1):
  - All lanes are accessed on the accept edge.
  - rsp_valid is high in the next cycle.
  - req_ready stays 1, so back-to-back requests sustain one vector per cycle.
- Strided (req_stride != 1):
  - States: IDLE -> SEQ -> IDLE.
  - Accept edge E0 enters SEQ and sets req_ready=0.
  - Lane k is accessed on edge E0+1+k.
  - The edge E0+LANES (last lane) returns to IDLE and registers the response.
  - rsp_valid and req_ready=1 occur in the cycle after that edge. Latency is LANES+1 cycles.
- Stride 0 store: lanes are written in ascending order, so the highest enabled lane wins.
- Stride 0 load: the word is broadcast to all enabled lanes.
- Store response: rsp_valid pulses, rsp_rdata=0, and rsp_err follows the rules above.
- Read-after-write: a load accepted in the cycle after a store completes sees the stored data. There is no stale read.
- rsp_rdata and rsp_err hold their values until the next response. rsp_valid is high for exactly one cycle per response.

Decomposition:
- Package vec_mem_pkg holds:
  - state_t enum {IDLE, SEQ}
  - lane_t (logic [DATA_W-1:0])
  - the WORD_SHIFT=2 constant
  - a function lane_in_range(base, stride, k, depth)
- Sub-module vec_mem_lane_gen: lane counter plus running word-address accumulator for SEQ.
  - Outputs: current lane index, word address, in-range flag, and a last-lane flag.
- Array, unit-stride path, FSM and response registers live in vec_mem_unit.

Test Plan:
- Unit-stride store at addr 0x0, mask 0xFF, data 50,100,11,23,1,2,3,4, then a unit-stride load at 0x0 -> load response the cycle after accept returns the same 8 words; rsp_err=0.
- Stride 2 load at addr 0x0 after storing index i at word i (i = 0..31) -> rsp_valid exactly LANES+1=9 cycles after accept with lanes 0,2,...,14; req_ready low for 8 cycles.
- Stride 0 store at addr 0x40, mask 0b1000_0110, lanes = k*10 -> word 16 holds 70; a stride 0 load returns 70 in enabled lanes and 0 in the others.
- Unit-stride load at addr 4*(DEPTH-4) -> lanes 0-3 carry data, lanes 4-7 are 0, rsp_err=1.
- Misaligned request at addr 0x2 -> no array change, rsp_err=1, rsp_rdata=0.
- Strided store with rst asserted on the 4th cycle of SEQ -> no rsp_valid, req_ready=1 after reset, lanes 0-2 written and lanes 3-7 unchanged.
